// File: rtl/sram_march_bist.sv
// March C- self-test engine driving a synchronous single-port SRAM at pin level.
// Define SRAM_MARCH_BIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module sram_march_bist #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int HALF_CYC = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] pattern,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_got,
   output logic              s_clk,
   output logic              s_cen,
   output logic              s_wen,
   output logic              s_oen,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_ddata,
   input  logic [DATA_W-1:0] s_qdata
);

   localparam int PH_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
   localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(HALF_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef SRAM_MARCH_BIST_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [2:0]        elem_q, elem_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [DATA_W-1:0] ddata_q, ddata_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [7:0]        err_q, err_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
   logic [DATA_W-1:0] fail_got_q, fail_got_d;

   logic              in_acc;
   logic              is_wr;
   logic              last_op;
   logic              down;
   logic              last_addr;
   logic [DATA_W-1:0] op_val;
   logic              phase_last;
   logic              mismatch;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         elem_q      <= '0;
         op_q        <= 1'b0;
         addr_q      <= '0;
         pat_q       <= '0;
         ddata_q     <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         pat_q       <= pat_d;
         ddata_q     <= ddata_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_exp_q  <= fail_exp_d;
         fail_got_q  <= fail_got_d;
      end
   end

   // Advance order inside an access: op within element, then address, then element.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      elem_d      = elem_q;
      op_d        = op_q;
      addr_d      = addr_q;
      pat_d       = pat_q;
      ddata_d     = ddata_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_got_d  = fail_got_q;
      phase_last  = (phase_q == PH_LAST);
      mismatch    = (state_q == HI) && phase_last && !is_wr && (s_qdata != op_val);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = LO;
               phase_d     = '0;
               elem_d      = '0;
               op_d        = 1'b0;
               addr_d      = '0;
               pat_d       = pattern;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_exp_d  = '0;
               fail_got_d  = '0;
            end
         end
         LO: begin
            if (phase_last) begin
               phase_d = '0;
               state_d = HI;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         HI: begin
            if (!phase_last) begin
               phase_d = phase_q + 1'b1;
            end else begin
               phase_d = '0;
               state_d = LO;
               if (is_wr)
                  ddata_d = op_val;
               if (mismatch) begin
                  if (err_q != 8'd255)
                     err_d = err_q + 8'd1;
                  if (err_q == 8'd0) begin
                     fail_addr_d = addr_q;
                     fail_exp_d  = op_val;
                     fail_got_d  = s_qdata;
                  end
               end
               if (!last_op) begin
                  op_d = 1'b1;
               end else begin
                  op_d = 1'b0;
                  if (!last_addr)
                     addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                  else if (elem_q == 3'd5)
                     state_d = FIN;
                  else begin
                     elem_d = elem_q + 3'd1;
                     addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                  end
               end
               if (STOP_ON_FAIL && mismatch)
                  state_d = FIN;
               if (state_d == FIN) begin
                  done_d = 1'b1;
                  pass_d = (err_d == 8'd0);
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Elements 1/3 read P then write Q, elements 2/4 read Q then write P.
   always_comb begin
      is_wr   = 1'b0;
      op_val  = pat_q;
      last_op = 1'b1;
      down    = (elem_q == 3'd3) || (elem_q == 3'd4);
      case (elem_q)
         3'd0: begin
            is_wr = 1'b1;
         end
         3'd1, 3'd3: begin
            is_wr   = op_q;
            op_val  = op_q ? ~pat_q : pat_q;
            last_op = op_q;
         end
         3'd2, 3'd4: begin
            is_wr   = op_q;
            op_val  = op_q ? pat_q : ~pat_q;
            last_op = op_q;
         end
         default: begin
            is_wr = 1'b0;
         end
      endcase
      last_addr = down ? (addr_q == '0) : (addr_q == ADDR_MAX);

      in_acc    = (state_q == LO) || (state_q == HI);
      busy      = in_acc;
      done      = done_q;
      pass      = pass_q;
      err_cnt   = err_q;
      fail_addr = fail_addr_q;
      fail_exp  = fail_exp_q;
      fail_got  = fail_got_q;
      s_clk     = (state_q == HI);
      s_cen     = !in_acc;
      s_wen     = !(in_acc && is_wr);
      s_oen     = !(in_acc && !is_wr);
      s_addr    = addr_q;
      s_ddata   = (in_acc && is_wr) ? op_val : ddata_q;
   end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- March C- built-in self-test engine for the 32x8 external test SRAM.
- Sits between the Avalon wrapper's control registers and the SRAM pins (s_clk, s_cen, s_wen, s_oen, s_addr, s_ddata, s_qdata).
- Generates pin-level access cycles, compares read data against expected values, and reports pass/fail, error count and first-failure details.

Parameters:
- ADDR_W, 5, SRAM address width; depth N = 2**ADDR_W.
- DATA_W, 8, SRAM data width.
- HALF_CYC, 2, clk cycles per s_clk half-period (min 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a test; ignored while busy
- pattern  in  DATA_W  background value "0"; "1" is ~pattern; sampled on accepted start
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- pass  out  1  valid when done; 1 = zero mismatches
- err_cnt  out  8  mismatch count, saturates at 255
- fail_addr  out  ADDR_W  address of first mismatch
- fail_exp  out  DATA_W  expected data at first mismatch
- fail_got  out  DATA_W  read data at first mismatch
- s_clk  out  1  SRAM clock; SRAM samples on its rising edge
- s_cen  out  1  chip enable, active low
- s_wen  out  1  write enable, active low
- s_oen  out  1  output enable, active low
- s_addr  out  ADDR_W  SRAM address
- s_ddata  out  DATA_W  write data
- s_qdata  in  DATA_W  read data

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - busy=0, done=0, pass=0, err_cnt=0, fail_*=0.
  - s_clk=0, s_cen=1, s_wen=1, s_oen=1, s_addr=0, s_ddata=0.
  - Reset mid-test aborts immediately with the same values; no partial result is retained.
- March sequence, with P = pattern and Q = ~P:
  - M0 up(wP)
  - M1 up(rP,wQ)
  - M2 up(rQ,wP)
  - M3 down(rP,wQ)
  - M4 down(rQ,wP)
  - M5 up(rP)
  - Total 10N accesses.
  - "up" runs address 0..N-1; "down" runs N-1..0. Address counter wraps only at element boundaries.
- FSM states: IDLE, LO, HI, NEXT, FIN.
  - IDLE: on start=1, latch pattern; clear done, pass, err_cnt, fail_*; set busy=1; go to LO with op=M0/op0, addr=0.
  - LO (HALF_CYC cycles):
    - s_clk=0, s_cen=0, s_addr=current address.
    - Write op: s_wen=0, s_oen=1, s_ddata=op value.
    - Read op: s_wen=1, s_oen=0, s_ddata holds its last value.
  - HI (HALF_CYC cycles): s_clk=1, other pins held. On the last HI cycle, a read op samples s_qdata and compares it to the expected value.
  - NEXT (0 cycles, merged into the last HI edge): advance op within the element, then address, then element. After M5 at addr N-1, go to FIN; otherwise go to LO.
  - FIN (1 cycle): s_cen=1, s_wen=1, s_oen=1, s_clk=0; busy=0, done=1, pass=(err_cnt==0); go to IDLE.
- Mismatch handling:
  - Each mismatch increments err_cnt, saturating at 255.
  - The first mismatch only (err_cnt==0 before the increment) captures fail_addr, fail_exp, fail_got.
- Timing:
  - Each access takes exactly 2*HALF_CYC clk cycles.
  - busy rises the cycle after start and stays high for 10N*2*HALF_CYC cycles (1280 at defaults).
  - done rises on the following cycle, together with busy falling.
- Simultaneous start and reset_n=0: reset wins.
- start pulse during busy or FIN: ignored.
- Outside an access, s_cen=1, s_wen=1, s_oen=1.

Optional Feature:
- Macro: SRAM_MARCH_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the test immediately. The FSM goes from the failing HI phase directly to FIN, giving err_cnt=1 and pass=0.
- Undefined: the full sequence always runs and all mismatches are counted.

Test Plan:
- Fault-free 32x8 model, pattern=0x55 -> busy high exactly 1280 cycles; done=1, pass=1, err_cnt=0, fail_*=0.
- Fault-free model, pattern=0x00 -> first 32 accesses write 0x00 at addr 0..31 ascending. Final element reads 0x00, ascending. pass=1.
- Model with addr 7 bit0 stuck-at-1, pattern=0x00 -> pass=0, err_cnt=3 (M1, M3, M5 reads), fail_addr=7, fail_exp=0x00, fail_got=0x01.
- Same fault with SRAM_MARCH_BIST_STOP_ON_FAIL_EN -> done asserts 1 cycle after the M1 read of addr 7. err_cnt=1; no accesses to addr 8 or later in M1.
- reset_n=0 for 1 cycle at cycle 500 of a run -> next cycle busy=0, done=0, s_cen=1, s_wen=1, s_oen=1. A new start then gives the full 1280-cycle run.
- start pulsed at cycle 100 during busy -> ignored; completion time unchanged; pattern not re-latched.
